// File: rtl/histo_equalizer.sv
`default_nettype none
// ============================================================================
// Module   : histo_equalizer
// Function : During vertical blanking, reads the 256-bin cumulative histogram,
//            finds cdf_min and total, computes the reciprocal
//            floor((OUT_MAX<<16)/(total-cdf_min)) with a restoring divider and
//            builds a 256 x 12 equalisation LUT. During the active frame every
//            Grey pixel goes through that LUT with a fixed two-cycle latency.
//            Before the first completed build the mapping is the identity.
// Options  : HEQ_LUT_DBUF_EN - double-buffered LUT. BUILD writes the shadow
//            bank and DONE swaps banks, so an aborted build never disturbs
//            the active mapping. Without it the single bank is written in
//            place.
// Timing   : a complete build needs at least 560 cycles of blanking.
// Revision : 1.0 - initial release
// ============================================================================
module histo_equalizer #(
   parameter int BINS    = 256,
   parameter int CDF_W   = 20,
   parameter int OUT_MAX = 4095
) (
   input  logic             iPclk,
   input  logic             iRst,
   input  logic             Fval,
   input  logic             Dval,
   input  logic [11:0]      Grey,
   output logic [7:0]       oCum_Addr,
   input  logic [CDF_W-1:0] iCum_Data,
   output logic [11:0]      oGrey,
   output logic             oDval,
   output logic             oFval,
   output logic             oLut_Valid,
   output logic [2:0]       stateOut
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_FIND  = 3'd1;
   localparam logic [2:0] c_DIV   = 3'd2;
   localparam logic [2:0] c_BUILD = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;

   localparam int             Q_W         = 28;
   localparam logic [8:0]     c_LAST_CNT  = 9'(BINS);
   localparam logic [8:0]     c_BUILD_END = 9'(BINS + 1);
   localparam logic [8:0]     c_DIV_END   = 9'(Q_W - 1);
   localparam logic [Q_W-1:0] c_DIVIDEND  = Q_W'(OUT_MAX * 65536);
   localparam logic [11:0]    c_OUT_MAX   = 12'(OUT_MAX);

   // FSM and build datapath state
   logic [2:0]       state_q, state_d;
   logic [8:0]       cnt_q;
   logic             found_q;
   logic [CDF_W-1:0] cdf_min_q;
   logic [CDF_W-1:0] total_q;
   logic             ident_q;
   logic [CDF_W-1:0] rem_q;
   logic [Q_W-1:0]   dvd_q;
   logic [Q_W-1:0]   recip_q;
   logic [31:0]      prod_q;
   logic             wr_en_q;
   logic [7:0]       wr_bin_q;
   logic             lut_valid_q;

   // Mapping pipeline state
   logic             fval_q;
   logic             dval1_q;
   logic [11:0]      grey1_q;
   logic [11:0]      rd_q;
   logic [11:0]      grey_o_q;
   logic             dval_o_q;
   logic             fval_o_q;

   // Combinational helpers
   logic             w_fall;
   logic             w_rise;
   logic [CDF_W-1:0] w_range;
   logic [CDF_W:0]   w_rem_sh;
   logic             w_ge;
   logic [CDF_W-1:0] w_rem_sub;
   logic [CDF_W-1:0] w_diff;
   logic [7:0]       w_bin;
   logic [11:0]      w_lut_wdata;
   logic [7:0]       w_cum_addr;

   // Frame edges are taken against the registered Fval of the mapping pipe
   assign w_fall = fval_q & ~Fval;
   assign w_rise = ~fval_q & Fval;

   // Restoring divider step: shift in the next dividend bit, subtract if it fits
   assign w_range   = total_q - cdf_min_q;
   assign w_rem_sh  = {rem_q, dvd_q[Q_W-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, w_range});
   assign w_rem_sub = w_rem_sh[CDF_W-1:0] - w_range;

   // Bins below cdf_min (leading empty bins) contribute zero
   assign w_diff = (iCum_Data < cdf_min_q) ? '0 : (iCum_Data - cdf_min_q);
   assign w_bin  = 8'(cnt_q - 9'd1);

   // LUT entry: identity ramp when the CDF is flat, otherwise saturated product
   assign w_lut_wdata = ident_q ? {wr_bin_q, 4'h0} :
                        ((prod_q > 32'(OUT_MAX)) ? c_OUT_MAX : prod_q[11:0]);

   // LUT storage, single or double banked
`ifdef HEQ_LUT_DBUF_EN
   localparam int LUT_AW = 9;
   logic              bank_q;
   logic [LUT_AW-1:0] w_wr_addr;
   logic [LUT_AW-1:0] w_rd_addr;
   assign w_wr_addr = {~bank_q, wr_bin_q};
   assign w_rd_addr = {bank_q, Grey[11:4]};

   // Active bank flips when a build completes
   always_ff @(posedge iPclk) begin
      if (iRst) begin
         bank_q <= 1'b0;
      end else if (state_q == c_DONE) begin
         bank_q <= ~bank_q;
      end
   end
`else
   localparam int LUT_AW = 8;
   logic [LUT_AW-1:0] w_wr_addr;
   logic [LUT_AW-1:0] w_rd_addr;
   assign w_wr_addr = wr_bin_q;
   assign w_rd_addr = Grey[11:4];
`endif

   logic [11:0] lut_mem [0:(1<<LUT_AW)-1];

   // FSM state register
   always_ff @(posedge iPclk) begin
      if (iRst) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a rising Fval aborts any build in progress
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE: begin
            if (w_fall) state_d = c_FIND;
         end
         c_FIND: begin
            if (w_rise)                   state_d = c_IDLE;
            else if (cnt_q == c_LAST_CNT) state_d = c_DIV;
         end
         c_DIV: begin
            if (w_rise)                                   state_d = c_IDLE;
            else if (w_range == '0 || cnt_q == c_DIV_END) state_d = c_BUILD;
         end
         c_BUILD: begin
            if (w_rise)                    state_d = c_IDLE;
            else if (cnt_q == c_BUILD_END) state_d = c_DONE;
         end
         c_DONE:  state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   // FSM outputs: CDF read address tracks the bin counter while scanning
   always_comb begin
      w_cum_addr = '0;
      if ((state_q == c_FIND || state_q == c_BUILD) && (cnt_q < c_LAST_CNT)) begin
         w_cum_addr = cnt_q[7:0];
      end
   end

   // Build datapath: min/total scan, reciprocal divide, LUT value pipeline
   always_ff @(posedge iPclk) begin
      if (iRst) begin
         cnt_q     <= '0;
         found_q   <= 1'b0;
         cdf_min_q <= '0;
         total_q   <= '0;
         ident_q   <= 1'b0;
         rem_q     <= '0;
         dvd_q     <= '0;
         recip_q   <= '0;
         prod_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_bin_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            c_IDLE: begin
               cnt_q <= '0;
               if (w_fall) begin
                  found_q   <= 1'b0;
                  cdf_min_q <= '0;
                  total_q   <= '0;
                  ident_q   <= 1'b0;
               end
            end
            c_FIND: begin
               cnt_q <= (state_d == c_FIND) ? (cnt_q + 9'd1) : '0;
               // read data lags the address by one cycle
               if (cnt_q != 9'd0 && !found_q && iCum_Data != '0) begin
                  found_q   <= 1'b1;
                  cdf_min_q <= iCum_Data;
               end
               if (cnt_q == c_LAST_CNT) begin
                  total_q <= iCum_Data;
                  rem_q   <= '0;
                  dvd_q   <= c_DIVIDEND;
                  recip_q <= '0;
               end
            end
            c_DIV: begin
               cnt_q <= (state_d == c_DIV) ? (cnt_q + 9'd1) : '0;
               if (w_range == '0) begin
                  ident_q <= 1'b1;
               end else begin
                  rem_q   <= w_ge ? w_rem_sub : w_rem_sh[CDF_W-1:0];
                  dvd_q   <= {dvd_q[Q_W-2:0], 1'b0};
                  recip_q <= {recip_q[Q_W-2:0], w_ge};
               end
            end
            c_BUILD: begin
               cnt_q <= (state_d == c_BUILD) ? (cnt_q + 9'd1) : '0;
               // data for bin cnt-1 is present; product written one cycle later
               if (cnt_q != 9'd0 && cnt_q <= c_LAST_CNT) begin
                  wr_en_q  <= 1'b1;
                  wr_bin_q <= w_bin;
                  prod_q   <= 32'(({{Q_W{1'b0}}, w_diff} * {{CDF_W{1'b0}}, recip_q}) >> 16);
               end
            end
            default: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

   // LUT valid flag: set by the first completed build, cleared only by reset
   always_ff @(posedge iPclk) begin
      if (iRst) begin
         lut_valid_q <= 1'b0;
      end else if (state_q == c_DONE) begin
         lut_valid_q <= 1'b1;
      end
   end

   // LUT write port
   always_ff @(posedge iPclk) begin
      if (wr_en_q) begin
         lut_mem[w_wr_addr] <= w_lut_wdata;
      end
   end

   // Two-stage mapping pipe: LUT read, then select LUT or identity output
   always_ff @(posedge iPclk) begin
      if (iRst) begin
         rd_q     <= '0;
         grey1_q  <= '0;
         dval1_q  <= 1'b0;
         fval_q   <= 1'b0;
         grey_o_q <= '0;
         dval_o_q <= 1'b0;
         fval_o_q <= 1'b0;
      end else begin
         rd_q     <= lut_mem[w_rd_addr];
         grey1_q  <= Grey;
         dval1_q  <= Dval;
         fval_q   <= Fval;
         grey_o_q <= lut_valid_q ? rd_q : grey1_q;
         dval_o_q <= dval1_q;
         fval_o_q <= fval_q;
      end
   end

   assign oCum_Addr  = w_cum_addr;
   assign oGrey      = grey_o_q;
   assign oDval      = dval_o_q;
   assign oFval      = fval_o_q;
   assign oLut_Valid = lut_valid_q;
   assign stateOut   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_histo_equalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_histo_equalizer
// Function : Self-checking bench for histo_equalizer. A CDF RAM model feeds
//            the DUT; an equalisation model computed directly from the CDF
//            table predicts every delayed output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_histo_equalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        Fval, Dval;
   logic [11:0] Grey;
   logic [7:0]  oCum_Addr;
   logic [19:0] cum_data;
   logic [11:0] oGrey;
   logic        oDval, oFval, oLut_Valid;
   logic [2:0]  stateOut;

   int checks = 0;
   int errors = 0;

   logic [19:0]  cdf [256];
   int unsigned  calc_lut [256];
   int unsigned  mdl_lut  [256];
   bit           mdl_known[256];
   bit           mdl_valid;
   bit           chk_en;

   // pipeline model of the input stream
   bit          m1_f, m1_d, m2_f, m2_d;
   logic [11:0] m1_g, m2_g;

   always #5 clk = ~clk;

   histo_equalizer dut (
      .iPclk      (clk),
      .iRst       (rst),
      .Fval       (Fval),
      .Dval       (Dval),
      .Grey       (Grey),
      .oCum_Addr  (oCum_Addr),
      .iCum_Data  (cum_data),
      .oGrey      (oGrey),
      .oDval      (oDval),
      .oFval      (oFval),
      .oLut_Valid (oLut_Valid),
      .stateOut   (stateOut)
   );

   // CDF RAM: one cycle read latency
   always @(posedge clk) cum_data <= cdf[oCum_Addr];

   // two-cycle delay line for the expected outputs
   always @(posedge clk) begin
      if (rst) begin
         m1_f = 0; m1_d = 0; m1_g = '0;
         m2_f = 0; m2_d = 0; m2_g = '0;
      end else begin
         m2_f = m1_f; m2_d = m1_d; m2_g = m1_g;
         m1_f = Fval; m1_d = Dval; m1_g = Grey;
      end
   end

   // continuous comparison of the delayed outputs
   always @(negedge clk) begin
      if (chk_en) begin
         int unsigned exp_g;
         checks++;
         if (oDval !== m2_d || oFval !== m2_f) begin
            errors++;
            $display("FAIL stream_valid: oDval=%b oFval=%b expected %b %b at %0t",
                     oDval, oFval, m2_d, m2_f, $time);
         end
         if (m2_d && (!mdl_valid || mdl_known[m2_g[11:4]])) begin
            exp_g = mdl_valid ? mdl_lut[m2_g[11:4]] : 32'(m2_g);
            checks++;
            if (32'(oGrey) !== exp_g) begin
               errors++;
               $display("FAIL stream_grey: grey_in=%h oGrey=%0d expected %0d at %0t",
                        m2_g, oGrey, exp_g, $time);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // equalisation LUT computed straight from the CDF table
   task automatic compute_lut();
      longint unsigned cmin, total, range, recip, v;
      bit found;
      found = 0; cmin = 0;
      for (int b = 0; b < 256; b++) begin
         if (!found && cdf[b] != 0) begin
            cmin  = cdf[b];
            found = 1;
         end
      end
      total = cdf[255];
      range = (total - cmin) & 64'hFFFFF;
      if (range == 0) begin
         for (int b = 0; b < 256; b++) calc_lut[b] = b * 16;
      end else begin
         recip = (64'd4095 * 64'd65536) / range;
         for (int b = 0; b < 256; b++) begin
            if (cdf[b] < cmin) v = 0;
            else               v = ((cdf[b] - cmin) * recip) >> 16;
            calc_lut[b] = (v > 4095) ? 4095 : 32'(v);
         end
      end
   endtask

   task automatic pix_check(input logic [11:0] g, input int unsigned exp, input string name);
      Dval = 1'b1;
      Grey = g;
      @(negedge clk);
      @(negedge clk);
      chk(name, 32'(oGrey), exp);
   endtask

   task automatic run_frame(input int n);
      Fval = 1'b1;
      for (int i = 0; i < n; i++) begin
         Dval = ($urandom_range(0, 3) != 0);
         Grey = 12'($urandom_range(0, 4095));
         @(negedge clk);
      end
   endtask

   task automatic blank(input int n);
      Fval = 1'b0;
      Dval = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (stateOut == s) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: state %0d not reached within %0d cycles (now %0d)",
                  name, s, budget, stateOut);
      end
   endtask

   // full build during blanking, then commit the model
   task automatic do_build(input string name);
      blank(600);
      compute_lut();
      for (int b = 0; b < 256; b++) begin
         mdl_lut[b]   = calc_lut[b];
         mdl_known[b] = 1;
      end
      mdl_valid = 1;
      chk(name, 32'(oLut_Valid), 1);
      chk({name, "_state"}, 32'(stateOut), 0);
      Fval = 1'b1;
   endtask

   task automatic random_cdf(input int zeros, input int step_max);
      int unsigned acc = 0;
      for (int b = 0; b < 256; b++) begin
         if (b >= zeros) acc += $urandom_range(0, step_max);
         cdf[b] = 20'(acc);
      end
   endtask

   initial begin
      rst = 1; Fval = 0; Dval = 0; Grey = '0;
      chk_en = 0; mdl_valid = 0;
      for (int b = 0; b < 256; b++) begin
         cdf[b] = '0; mdl_lut[b] = 0; mdl_known[b] = 1;
      end
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_oGrey", 32'(oGrey), 0);
      chk("rst_oDval", 32'(oDval), 0);
      chk("rst_oFval", 32'(oFval), 0);
      chk("rst_valid", 32'(oLut_Valid), 0);
      chk("rst_addr",  32'(oCum_Addr), 0);
      chk("rst_state", 32'(stateOut), 0);
      rst = 0;
      chk_en = 1;

      // identity before any build
      Fval = 1;
      pix_check(12'h645, 32'h645, "identity_pre");
      chk("valid_pre", 32'(oLut_Valid), 0);
      run_frame(150);

      // linear CDF: recip = 1052431
      for (int b = 0; b < 256; b++) cdf[b] = 20'(b + 1);
      do_build("linear_valid");
      pix_check(12'h000, 0,    "linear_bin0");
      pix_check(12'h800, 2055, "linear_bin128");
      pix_check(12'hFFF, 4094, "linear_bin255");
      run_frame(200);

      // leading empty bins: bins 0..10 map to zero, bin 255 near full scale
      for (int b = 0; b < 256; b++) cdf[b] = (b < 10) ? 20'd0 : 20'(b - 9);
      do_build("lead_valid");
      pix_check(12'h050, 0,    "lead_bin5");
      pix_check(12'h0A5, 0,    "lead_bin10");
      pix_check(12'hFFF, 4094, "lead_bin255");
      run_frame(200);

      // single-bin image: flat range selects the identity ramp
      for (int b = 0; b < 256; b++) cdf[b] = (b < 100) ? 20'd0 : 20'd1000;
      do_build("flat_valid");
      pix_check(12'h645, 32'h640, "flat_645");
      pix_check(12'h123, 32'h120, "flat_123");
      run_frame(200);

      // randomized CDF shapes
      random_cdf(int'($urandom_range(0, 40)), 300);
      do_build("rand1_valid");
      run_frame(300);
      random_cdf(int'($urandom_range(0, 5)), 4000);
      do_build("rand2_valid");
      run_frame(300);

      // abort 100 cycles into BUILD
      random_cdf(int'($urandom_range(0, 20)), 2000);
      compute_lut();
      blank(0);
      wait_state(3'd3, 800, "abort_reach_build");
      repeat (100) @(negedge clk);
      Fval = 1;
      @(negedge clk);
      chk("abort_state", 32'(stateOut), 0);
      chk("abort_valid", 32'(oLut_Valid), 1);
`ifndef HEQ_LUT_DBUF_EN
      for (int b = 0; b < 110; b++) begin
         if (b < 90) mdl_lut[b] = calc_lut[b];
         else        mdl_known[b] = 0;
      end
`endif
      pix_check(12'h14A, mdl_lut[20],  "abort_bin20");
      pix_check(12'hC83, mdl_lut[200], "abort_bin200");
      run_frame(300);

      // complete build of the same table afterwards
      do_build("rebuild_valid");
      pix_check(12'h14A, calc_lut[20], "rebuild_bin20");
      run_frame(300);

      // reset during DIV
      blank(0);
      wait_state(3'd2, 400, "reach_div");
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rstdiv_state", 32'(stateOut), 0);
      chk("rstdiv_valid", 32'(oLut_Valid), 0);
      chk("rstdiv_oGrey", 32'(oGrey), 0);
      chk("rstdiv_oDval", 32'(oDval), 0);
      chk("rstdiv_oFval", 32'(oFval), 0);
      mdl_valid = 0;
      for (int b = 0; b < 256; b++) mdl_known[b] = 1;
      Fval = 1;
      pix_check(12'h645, 32'h645, "identity_post_rst");
      run_frame(200);
      blank(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
